// File: rtl/core_dispatch_queue_if.sv
// ----------------------------------------------------------------------------
// core_dispatch_queue_if
//   Bundles the cpu0 request handshake and the registered dispatch pulse that
//   goes to the core start controller.
//
//   Handshake: a request transfers on a rising clk edge where both req_valid
//   and req_ready are high. req_cpu_num/req_adr must be stable while req_valid
//   is high. req_ready does not depend on req_valid.
//
//   Signals
//     req_valid      master -> slave   request valid
//     req_ready      slave  -> master  queue can accept this cycle
//     req_cpu_num    master -> slave   target core (2'b01 = cpu1, 2'b10 = cpu2)
//     req_adr        master -> slave   start PC
//     cpu0_control   slave  -> master  one-cycle dispatch strobe
//     start_cpu_num  slave  -> master  dispatched core number, 0 when idle
//     cpu_start_adr  slave  -> master  dispatched start PC, 0 when idle
//
//   Modports: master = request issuer (cpu0 side), slave = the queue.
// ----------------------------------------------------------------------------
interface core_dispatch_queue_if #(
    parameter int PC_W = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_cpu_num;
    logic [PC_W-1:0] req_adr;
    logic            cpu0_control;
    logic [1:0]      start_cpu_num;
    logic [PC_W-1:0] cpu_start_adr;

    modport master (
        output req_valid,
        output req_cpu_num,
        output req_adr,
        input  req_ready,
        input  cpu0_control,
        input  start_cpu_num,
        input  cpu_start_adr
    );

    modport slave (
        input  req_valid,
        input  req_cpu_num,
        input  req_adr,
        output req_ready,
        output cpu0_control,
        output start_cpu_num,
        output cpu_start_adr
    );
endinterface

// File: rtl/core_dispatch_queue.sv
// ----------------------------------------------------------------------------
// core_dispatch_queue
//   In-order FIFO of core-start requests from cpu0. The head entry is issued
//   as a one-cycle registered strobe (cpu0_control with start_cpu_num and
//   cpu_start_adr) only once its target core reports idle on core_state.
//   A busy head core blocks all later entries. One dispatch per 3 cycles max
//   (IDLE -> ISSUE -> WAIT -> IDLE).
//
//   Optional feature: define CORE_DISPATCH_FLUSH_EN to add the flush input,
//   which empties the queue at the next edge and blocks pushes while high.
//
//   Ports
//     clk         in   system clock
//     rst         in   asynchronous, active-low reset
//     bus         slave modport of core_dispatch_queue_if (request handshake
//                 and registered dispatch outputs)
//     core_state  in   {cpu2_idle, cpu1_idle, 1'b0} from the start controller
//     flush       in   (CORE_DISPATCH_FLUSH_EN only) empty the queue
//     q_count     out  number of queued entries, 0..DEPTH
//     drop_err    out  sticky: a request with cpu_num 00/11 was consumed
//     dbg_state   out  current FSM state (00 IDLE, 01 ISSUE, 10 WAIT)
// ----------------------------------------------------------------------------
module core_dispatch_queue #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    core_dispatch_queue_if.slave bus,
    input  logic [2:0]           core_state,
`ifdef CORE_DISPATCH_FLUSH_EN
    input  logic                 flush,
`endif
    output logic [AW:0]          q_count,
    output logic                 drop_err,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;

    logic [1:0]      num_mem [DEPTH];
    logic [PC_W-1:0] adr_mem [DEPTH];

    logic            full;
    logic            empty;
    logic            flush_act;
    logic            accept;
    logic            num_ok;
    logic            push;
    logic            pop;
    logic [1:0]      head_num;
    logic [PC_W-1:0] head_adr;

`ifdef CORE_DISPATCH_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Full/empty come from the occupancy counter so the pointers can stay AW
    // bits wide and simply wrap.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Ready is held low during reset and while flushing. There is no bypass
    // when full: a pop in the same cycle does not open a slot early.
    assign bus.req_ready = rst & ~full & ~flush_act;

    assign accept = bus.req_valid & bus.req_ready;
    assign num_ok = (bus.req_cpu_num == 2'b01) || (bus.req_cpu_num == 2'b10);
    // Invalid core numbers are consumed by the handshake but never stored.
    assign push   = accept & num_ok;

    assign head_num = num_mem[rd_ptr_q];
    assign head_adr = adr_mem[rd_ptr_q];

    // Only stored entries reach the head, so head_num is always 01 or 10 and
    // selects the matching idle bit. A flush holds the FSM in IDLE.
    assign pop = (state_q == ST_IDLE) & ~empty & ~flush_act & core_state[head_num];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pop) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            // WAIT gives the controller one edge to drop the idle bit of the
            // core just started, so it is not sampled stale in IDLE.
            ST_WAIT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_act) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            num_mem[wr_ptr_q] <= bus.req_cpu_num;
            adr_mem[wr_ptr_q] <= bus.req_adr;
        end
    end

    // ------------------------------------------------------------------
    // Registered dispatch outputs: loaded on the IDLE->ISSUE edge, cleared
    // on the following edge, so they are non-zero only during ISSUE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.cpu0_control  <= 1'b0;
            bus.start_cpu_num <= 2'b00;
            bus.cpu_start_adr <= '0;
        end else if (pop) begin
            bus.cpu0_control  <= 1'b1;
            bus.start_cpu_num <= head_num;
            bus.cpu_start_adr <= head_adr;
        end else begin
            bus.cpu0_control  <= 1'b0;
            bus.start_cpu_num <= 2'b00;
            bus.cpu_start_adr <= '0;
        end
    end

    // Sticky error for consumed requests with an unusable core number.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_err <= 1'b0;
        end else if (accept && !num_ok) begin
            drop_err <= 1'b1;
        end
    end

    assign q_count   = count_q;
    assign dbg_state = state_q;

endmodule
